// File: rtl/regacc_pkg.sv
// Shared encodings for the register-port arbiter: access kinds, FSM states,
// the latched request record and the port widths.
package regacc_pkg;

  localparam int ACC_DATA_W = 32;
  localparam int ACC_REG_W  = 4;

  typedef enum logic [1:0] {
    KIND_REG_RD  = 2'b00,
    KIND_REG_WR  = 2'b01,
    KIND_CPSR_RD = 2'b10,
    KIND_CPSR_WR = 2'b11
  } acc_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_ACK   = 2'b11
  } acc_state_e;

  typedef struct packed {
    acc_kind_e             kind;
    logic [ACC_REG_W-1:0]  regIdx;
    logic [ACC_DATA_W-1:0] wdata;
    logic                  restore;
  } acc_req_t;

  // Bit 0 of the kind separates writes from reads, bit 1 selects the CPSR.
  function automatic logic isWrite(input acc_kind_e kind);
    return kind[0];
  endfunction

  function automatic logic isCpsr(input acc_kind_e kind);
    return kind[1];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection: round-robin when FAIR is non-zero, otherwise
// client 0 always wins a tie. The favour pointer advances on each completion.
module rr_arbiter2 #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_granted,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_favour;
  logic w_rrGrant;

  // r_favour names the client that wins the next tie: the one not granted last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_favour <= 1'b0;
    end else if (i_update) begin
      r_favour <= ~i_granted;
    end
  end

  always_comb begin
    w_rrGrant = 1'b0;
    if (i_req == 2'b11) begin
      w_rrGrant = r_favour;
    end else if (i_req[1]) begin
      w_rrGrant = 1'b1;
    end
  end

  assign o_valid = |i_req;
  assign o_grant = (FAIR != 0) ? w_rrGrant : ~i_req[0];

endmodule

// File: rtl/reg_port_arbiter.sv
// Serialises register-file and CPSR accesses from two clients onto a single
// register-file port, one transaction in flight at a time.
module reg_port_arbiter
  import regacc_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c0_req,
  input  logic [1:0]            c0_kind,
  input  logic [ACC_REG_W-1:0]  c0_reg,
  input  logic [ACC_DATA_W-1:0] c0_wdata,
  input  logic                  c0_restore,
  output logic                  c0_ack,
  output logic [ACC_DATA_W-1:0] c0_rdata,
  input  logic                  c1_req,
  input  logic [1:0]            c1_kind,
  input  logic [ACC_REG_W-1:0]  c1_reg,
  input  logic [ACC_DATA_W-1:0] c1_wdata,
  input  logic                  c1_restore,
  output logic                  c1_ack,
  output logic [ACC_DATA_W-1:0] c1_rdata,
  output logic                  rf_read_en,
  output logic                  rf_write_en,
  output logic                  rf_cpsr_read_en,
  output logic                  rf_cpsr_write_en,
  output logic [ACC_REG_W-1:0]  rf_read_reg,
  output logic [ACC_REG_W-1:0]  rf_write_reg,
  output logic [ACC_DATA_W-1:0] rf_write_value,
  output logic [ACC_DATA_W-1:0] rf_cpsr_write_value,
  output logic                  rf_write_restore_from_SPSR,
  input  logic [ACC_DATA_W-1:0] rf_read_value,
  input  logic [ACC_DATA_W-1:0] rf_cpsr_read_value,
  output logic                  busy
);

  acc_state_e            r_state;
  acc_state_e            w_next;
  acc_req_t              r_txn;
  acc_req_t              w_sel;
  logic                  r_grant;
  logic [ACC_DATA_W-1:0] r_data;
  logic [ACC_DATA_W-1:0] r_c0Rdata;
  logic [ACC_DATA_W-1:0] r_c1Rdata;
  logic [ACC_DATA_W-1:0] w_capture;
  logic                  w_arbValid;
  logic                  w_arbGrant;
  logic                  w_start;
  logic                  w_inAck;

  rr_arbiter2 #(
    .FAIR(FAIR)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     ({c1_req, c0_req}),
    .i_update  (w_inAck),
    .i_granted (r_grant),
    .o_valid   (w_arbValid),
    .o_grant   (w_arbGrant)
  );

  assign w_start = (r_state == ST_IDLE) && w_arbValid;
  assign w_inAck = (r_state == ST_ACK);

  always_comb begin
    w_sel.kind    = acc_kind_e'(c0_kind);
    w_sel.regIdx  = c0_reg;
    w_sel.wdata   = c0_wdata;
    w_sel.restore = c0_restore;
    if (w_arbGrant) begin
      w_sel.kind    = acc_kind_e'(c1_kind);
      w_sel.regIdx  = c1_reg;
      w_sel.wdata   = c1_wdata;
      w_sel.restore = c1_restore;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_arbValid) w_next = ST_ISSUE;
      ST_ISSUE: w_next = isWrite(r_txn.kind) ? ST_ACK : ST_WAIT;
      ST_WAIT:  w_next = ST_ACK;
      ST_ACK:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_read_en       = 1'b0;
    rf_write_en      = 1'b0;
    rf_cpsr_read_en  = 1'b0;
    rf_cpsr_write_en = 1'b0;
    c0_ack           = 1'b0;
    c1_ack           = 1'b0;
    busy             = (r_state != ST_IDLE);
    case (r_state)
      ST_ISSUE: begin
        case (r_txn.kind)
          KIND_REG_RD:  rf_read_en       = 1'b1;
          KIND_REG_WR:  rf_write_en      = 1'b1;
          KIND_CPSR_RD: rf_cpsr_read_en  = 1'b1;
          KIND_CPSR_WR: rf_cpsr_write_en = 1'b1;
          default:      rf_read_en       = 1'b0;
        endcase
      end
      ST_ACK: begin
        c0_ack = ~r_grant;
        c1_ack = r_grant;
      end
      default: busy = (r_state != ST_IDLE);
    endcase
  end

  // Fields are frozen at grant so later client-side changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn   <= '0;
      r_grant <= 1'b0;
    end else if (w_start) begin
      r_txn   <= w_sel;
      r_grant <= w_arbGrant;
    end
  end

  always_comb begin
    w_capture = r_data;
    if (r_state == ST_ISSUE && isWrite(r_txn.kind)) begin
      w_capture = '0;
    end else if (r_state == ST_WAIT) begin
      w_capture = isCpsr(r_txn.kind) ? rf_cpsr_read_value : rf_read_value;
    end
  end

  // Per-client holding registers keep the last completed result between acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_c0Rdata <= '0;
      r_c1Rdata <= '0;
    end else begin
      r_data <= w_capture;
      if (w_inAck && !r_grant) r_c0Rdata <= r_data;
      if (w_inAck && r_grant)  r_c1Rdata <= r_data;
    end
  end

  assign c0_rdata = (w_inAck && !r_grant) ? r_data : r_c0Rdata;
  assign c1_rdata = (w_inAck && r_grant)  ? r_data : r_c1Rdata;

  assign rf_read_reg                = r_txn.regIdx;
  assign rf_write_reg               = r_txn.regIdx;
  assign rf_write_value             = r_txn.wdata;
  assign rf_cpsr_write_value        = r_txn.wdata;
  assign rf_write_restore_from_SPSR = r_txn.restore && (r_txn.kind == KIND_REG_WR);

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter: directed transactions push expected
// acks and register-file writes, a negedge monitor pops and compares them.
module tb_reg_port_arbiter;
  import regacc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        c0_req, c1_req;
  logic [1:0]  c0_kind, c1_kind;
  logic [3:0]  c0_reg, c1_reg;
  logic [31:0] c0_wdata, c1_wdata;
  logic        c0_restore, c1_restore;
  logic        c0_ack, c1_ack;
  logic [31:0] c0_rdata, c1_rdata;
  logic        rf_read_en, rf_write_en, rf_cpsr_read_en, rf_cpsr_write_en;
  logic [3:0]  rf_read_reg, rf_write_reg;
  logic [31:0] rf_write_value, rf_cpsr_write_value;
  logic        rf_write_restore_from_SPSR;
  logic [31:0] rf_read_value = 32'd0;
  logic [31:0] rf_cpsr_read_value = 32'd0;
  logic        busy;

  logic        f_c0_ack, f_c1_ack;
  logic [31:0] f_c0_rdata, f_c1_rdata;
  logic        f_rd, f_wr, f_crd, f_cwr;
  logic [3:0]  f_rreg, f_wreg;
  logic [31:0] f_wval, f_cwval;
  logic        f_restore, f_busy;

  always #5 clk = ~clk;

  reg_port_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_kind(c0_kind), .c0_reg(c0_reg), .c0_wdata(c0_wdata),
    .c0_restore(c0_restore), .c0_ack(c0_ack), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_kind(c1_kind), .c1_reg(c1_reg), .c1_wdata(c1_wdata),
    .c1_restore(c1_restore), .c1_ack(c1_ack), .c1_rdata(c1_rdata),
    .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
    .rf_cpsr_read_en(rf_cpsr_read_en), .rf_cpsr_write_en(rf_cpsr_write_en),
    .rf_read_reg(rf_read_reg), .rf_write_reg(rf_write_reg),
    .rf_write_value(rf_write_value), .rf_cpsr_write_value(rf_cpsr_write_value),
    .rf_write_restore_from_SPSR(rf_write_restore_from_SPSR),
    .rf_read_value(rf_read_value), .rf_cpsr_read_value(rf_cpsr_read_value),
    .busy(busy)
  );

  reg_port_arbiter #(.FAIR(0)) dutFixed (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_kind(c0_kind), .c0_reg(c0_reg), .c0_wdata(c0_wdata),
    .c0_restore(c0_restore), .c0_ack(f_c0_ack), .c0_rdata(f_c0_rdata),
    .c1_req(c1_req), .c1_kind(c1_kind), .c1_reg(c1_reg), .c1_wdata(c1_wdata),
    .c1_restore(c1_restore), .c1_ack(f_c1_ack), .c1_rdata(f_c1_rdata),
    .rf_read_en(f_rd), .rf_write_en(f_wr),
    .rf_cpsr_read_en(f_crd), .rf_cpsr_write_en(f_cwr),
    .rf_read_reg(f_rreg), .rf_write_reg(f_wreg),
    .rf_write_value(f_wval), .rf_cpsr_write_value(f_cwval),
    .rf_write_restore_from_SPSR(f_restore),
    .rf_read_value(rf_read_value), .rf_cpsr_read_value(rf_cpsr_read_value),
    .busy(f_busy)
  );

  typedef struct { int cl; logic [31:0] rdata; int lat; } ack_exp_t;
  typedef struct { bit cpsr; logic [3:0] idx; logic [31:0] val; bit restore; } wr_exp_t;

  ack_exp_t    ackQ[$];
  wr_exp_t     wrQ[$];
  int          nCompared = 0;
  int          nMismatch = 0;
  int          cyc = 0;
  int          reqCyc[2];
  int          rdStrobes = 0;
  int          f0Acks = 0;
  int          f1Acks = 0;
  logic [31:0] lastRdata[2];
  logic [31:0] rfMem[16];
  logic [31:0] cpsrMem = 32'd0;

  // Register-file model: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_write_en) rfMem[rf_write_reg] <= rf_write_value;
    if (rf_cpsr_write_en) cpsrMem <= rf_cpsr_write_value;
    if (rf_read_en) rf_read_value <= rfMem[rf_read_reg];
    if (rf_cpsr_read_en) rf_cpsr_read_value <= cpsrMem;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  ack_exp_t eA;
  wr_exp_t  eW;
  int       actCl;
  int       nStr;

  always @(negedge clk) begin
    nStr = 32'(rf_read_en) + 32'(rf_write_en) + 32'(rf_cpsr_read_en) + 32'(rf_cpsr_write_en);
    if (rf_read_en) rdStrobes++;
    if (f_c0_ack) f0Acks++;
    if (f_c1_ack) f1Acks++;
    if (!rst_n) begin
      lastRdata[0] = 32'd0;
      lastRdata[1] = 32'd0;
    end else begin
      if (nStr != 0) checkOutput("strobe_onehot", 32'(nStr), 32'd1);
      if (f_c0_ack || f_c1_ack) checkOutput("fixed_ack_exclusive", 32'(f_c0_ack & f_c1_ack), 32'd0);
      if (c0_ack || c1_ack) begin
        checkOutput("ack_exclusive", 32'(c0_ack & c1_ack), 32'd0);
        actCl = c1_ack ? 1 : 0;
        if (ackQ.size() == 0) begin
          checkOutput("unexpected_ack", {30'd0, c1_ack, c0_ack}, 32'd0);
        end else begin
          eA = ackQ.pop_front();
          checkOutput("ack_client", 32'(actCl), 32'(eA.cl));
          checkOutput("ack_rdata", (actCl == 1) ? c1_rdata : c0_rdata, eA.rdata);
          if (eA.lat > 0) checkOutput("ack_latency", 32'(cyc - reqCyc[actCl]), 32'(eA.lat - 1));
          checkOutput("rdata_hold", (actCl == 1) ? c0_rdata : c1_rdata, lastRdata[1 - actCl]);
          lastRdata[actCl] = eA.rdata;
        end
      end
      if (rf_write_en || rf_cpsr_write_en) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", {30'd0, rf_cpsr_write_en, rf_write_en}, 32'd0);
        end else begin
          eW = wrQ.pop_front();
          checkOutput("write_is_cpsr", 32'(rf_cpsr_write_en), 32'(eW.cpsr));
          if (eW.cpsr) begin
            checkOutput("cpsr_write_value", rf_cpsr_write_value, eW.val);
          end else begin
            checkOutput("write_reg", 32'(rf_write_reg), 32'(eW.idx));
            checkOutput("write_value", rf_write_value, eW.val);
            checkOutput("write_restore", 32'(rf_write_restore_from_SPSR), 32'(eW.restore));
          end
        end
      end
    end
  end

  task automatic expectAck(input int cl, input logic [31:0] rdata, input int lat);
    ack_exp_t e;
    e.cl = cl; e.rdata = rdata; e.lat = lat;
    ackQ.push_back(e);
  endtask

  task automatic expectWrite(input bit cpsr, input logic [3:0] idx, input logic [31:0] val, input bit restore);
    wr_exp_t e;
    e.cpsr = cpsr; e.idx = idx; e.val = val; e.restore = restore;
    wrQ.push_back(e);
  endtask

  task automatic driveClient(input int cl, input logic rq, input logic [1:0] k,
                             input logic [3:0] idx, input logic [31:0] wd, input logic rs);
    if (cl == 0) begin
      c0_req = rq; c0_kind = k; c0_reg = idx; c0_wdata = wd; c0_restore = rs;
    end else begin
      c1_req = rq; c1_kind = k; c1_reg = idx; c1_wdata = wd; c1_restore = rs;
    end
  endtask

  // One transaction; with mutate set, the fields change and req drops in the ISSUE cycle.
  task automatic applyStimulus(input int cl, input logic [1:0] kind, input logic [3:0] idx,
                               input logic [31:0] wdata, input logic restore, input bit mutate);
    bit got = 0;
    @(negedge clk);
    driveClient(cl, 1'b1, kind, idx, wdata, restore);
    reqCyc[cl] = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mutate && i == 0) driveClient(cl, 1'b0, kind, ~idx, ~wdata, ~restore);
      if ((cl == 0) ? c0_ack : c1_ack) got = 1;
    end
    if (cl == 0) c0_req = 1'b0; else c1_req = 1'b0;
    checkOutput("ack_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int n;
    int rdBase;
    int fBase0, fBase1;
    for (int i = 0; i < 16; i++) rfMem[i] = 32'd0;
    driveClient(0, 1'b0, 2'b00, 4'd0, 32'd0, 1'b0);
    driveClient(1, 1'b0, 2'b00, 4'd0, 32'd0, 1'b0);

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_acks", {30'd0, c1_ack, c0_ack}, 32'd0);
    checkOutput("reset_strobes", {28'd0, rf_read_en, rf_write_en, rf_cpsr_read_en, rf_cpsr_write_en}, 32'd0);
    checkOutput("reset_c0_rdata", c0_rdata, 32'd0);
    checkOutput("reset_c1_rdata", c1_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    expectWrite(0, 4'd1, 32'd5, 0); expectAck(0, 32'd0, 3);
    applyStimulus(0, KIND_REG_WR, 4'd1, 32'd5, 1'b0, 0);
    expectAck(0, 32'd5, 4);
    applyStimulus(0, KIND_REG_RD, 4'd1, 32'd0, 1'b0, 0);

    expectWrite(0, 4'd2, 32'd7, 0); expectAck(1, 32'd0, 3);
    applyStimulus(1, KIND_REG_WR, 4'd2, 32'd7, 1'b0, 0);
    expectWrite(0, 4'd4, 32'd20, 0); expectAck(1, 32'd0, 3);
    applyStimulus(1, KIND_REG_WR, 4'd4, 32'd20, 1'b0, 0);

    expectAck(0, 32'd7, 4); expectAck(1, 32'd20, -1);
    fork
      applyStimulus(0, KIND_REG_RD, 4'd2, 32'd0, 1'b0, 0);
      applyStimulus(1, KIND_REG_RD, 4'd4, 32'd0, 1'b0, 0);
    join

    expectWrite(1, 4'd0, 32'h2000_0000, 0); expectAck(1, 32'd0, 3);
    applyStimulus(1, KIND_CPSR_WR, 4'd0, 32'h2000_0000, 1'b0, 0);
    expectAck(1, 32'h2000_0000, 4);
    applyStimulus(1, KIND_CPSR_RD, 4'd0, 32'd0, 1'b0, 0);

    expectWrite(0, 4'd3, 32'h0000_A5A5, 1); expectAck(0, 32'd0, 3);
    applyStimulus(0, KIND_REG_WR, 4'd3, 32'h0000_A5A5, 1'b1, 1);
    expectAck(0, 32'h0000_A5A5, 4);
    applyStimulus(0, KIND_REG_RD, 4'd3, 32'd0, 1'b0, 0);
    expectAck(0, 32'd0, 4);
    applyStimulus(0, KIND_REG_RD, 4'd12, 32'd0, 1'b0, 0);

    rdBase = rdStrobes;
    @(negedge clk);
    driveClient(0, 1'b1, KIND_REG_RD, 4'd1, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_in_wait", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    c0_req = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_strobes", {28'd0, rf_read_en, rf_write_en, rf_cpsr_read_en, rf_cpsr_write_en}, 32'd0);
    checkOutput("abort_acks", {30'd0, c1_ack, c0_ack}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_read_strobe_once", 32'(rdStrobes - rdBase), 32'd1);
    rst_n = 1'b1;
    expectAck(1, 32'd5, 4);
    applyStimulus(1, KIND_REG_RD, 4'd1, 32'd0, 1'b0, 0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fBase0 = f0Acks;
    fBase1 = f1Acks;
    for (int i = 0; i < 8; i++) expectAck(i % 2, (i % 2 == 1) ? 32'd20 : 32'd7, -1);
    @(negedge clk);
    driveClient(0, 1'b1, KIND_REG_RD, 4'd2, 32'd0, 1'b0);
    driveClient(1, 1'b1, KIND_REG_RD, 4'd4, 32'd0, 1'b0);
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      @(negedge clk);
      if (c0_ack || c1_ack) n++;
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("fair_ack_count", 32'(n), 32'd8);
    checkOutput("fixed_c0_acks", 32'(f0Acks - fBase0), 32'd8);
    checkOutput("fixed_c1_starved", 32'(f1Acks - fBase1), 32'd0);
    checkOutput("ack_queue_drained", 32'(ackQ.size()), 32'd0);
    checkOutput("write_queue_drained", 32'(wrQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/reg_port_arbiter.md
REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

Interface
REQ-001 Parameter FAIR, default 1; 1 = round-robin between clients, 0 = fixed priority to client 0.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cN_req (N=0,1)  input  1  client request, held high until cN_ack.
REQ-005 cN_kind  input  2  access kind: 00 reg read, 01 reg write, 10 CPSR read, 11 CPSR write.
REQ-006 cN_reg  input  4  register index for reg read/write.
REQ-007 cN_wdata  input  32  write data for reg or CPSR write.
REQ-008 cN_restore  input  1  on reg write, forwarded as restore-from-SPSR.
REQ-009 cN_ack  output  1  one-cycle completion pulse to client N.
REQ-010 cN_rdata  output  32  read data, valid in the cN_ack cycle.
REQ-011 rf_read_en, rf_write_en, rf_cpsr_read_en, rf_cpsr_write_en  output  1 each  register-file strobes.
REQ-012 rf_read_reg, rf_write_reg  output  4  register-file indices.
REQ-013 rf_write_value, rf_cpsr_write_value  output  32  register-file write data.
REQ-014 rf_write_restore_from_SPSR  output  1  forwarded restore flag.
REQ-015 rf_read_value, rf_cpsr_read_value  input  32  register-file read data, valid the cycle after the matching read strobe.
REQ-016 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, ACK; one transaction in flight at a time.
REQ-018 IDLE: if any cN_req high, select a winner, latch its kind/reg/wdata/restore, go ISSUE; else stay.
REQ-019 Round-robin: single requester wins; both requesting -> client other than last granted wins; pointer after reset favours client 0; FAIR=0 -> client 0 always wins ties.
REQ-020 ISSUE: assert exactly one rf strobe for one cycle with latched fields; writes go to ACK, reads go to WAIT.
REQ-021 WAIT: capture rf_read_value (reg read) or rf_cpsr_read_value (CPSR read) into data register; go ACK.
REQ-022 ACK: pulse cN_ack for the granted client only, cN_rdata = captured data (writes: 0); update last-granted pointer; go IDLE.
REQ-023 Latency from req sampled in IDLE to ack: write 3 cycles, read 4 cycles; back-to-back transactions re-enter IDLE for one cycle minimum.
REQ-024 Latched fields are immune to client input changes after grant; a client dropping req before ack still receives its ack.
REQ-025 Client that sees ack and keeps req high is treated as a new request in the following IDLE cycle.
REQ-026 All rf strobes low outside ISSUE; no two strobes ever high together.
REQ-027 cN_rdata holds its value between acks.

Reset
REQ-028 rst_n low: FSM to IDLE, all strobes/acks/busy 0, data and latched fields 0, pointer to client 0, immediately and without a clock edge.
REQ-029 Reset mid-transaction aborts it: no ack issued, a strobe already issued is not reissued.

Structure
REQ-030 Shared package regacc_pkg holds kind encodings, FSM state encoding and ACC_DATA_W=32 / ACC_REG_W=4.
REQ-031 Sub-module rr_arbiter2 implements the two-way round-robin/fixed grant selection and pointer; the FSM and datapath stay in reg_port_arbiter.

Verification
REQ-032 c0 reg write r1=5, then c0 reg read r1 -> rf_write_en one cycle with reg 1 value 5, c0_ack after 3 cycles; read ack after 4 cycles with c0_rdata=5.
REQ-033 c0 and c1 both request reads (r2=7, r4=20) in the same cycle -> c0 served first (rdata 7), c1 second (rdata 20), never both acks together.
REQ-034 Both clients hold continuous requests for 8 transactions with FAIR=1 -> grants alternate 0,1,0,1...; FAIR=0 -> client 0 starves client 1.
REQ-035 c1 CPSR write 0x2000_0000 then CPSR read -> rf_cpsr_write_en pulse with that value, read ack returns 0x2000_0000.
REQ-036 c0 changes cN_reg/wdata and drops req one cycle after grant -> original fields used, ack still pulsed.
REQ-037 Assert rst_n low during WAIT -> busy 0 and strobes 0 asynchronously, no ack; next request completes normally.
